// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and defaults for the bit-serial adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder around one full_adder cell
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == LAST);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            s_sh     <= '0;
            c_q      <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                a_sh <= a_in;
                b_sh <= b_in;
                s_sh <= '0;
                c_q  <= cin_in;
                cnt  <= '0;
            end else if (state == ST_RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                s_sh <= {fa_sum, s_sh[WIDTH-1:1]};
                c_q  <= fa_cout;
                // Hold the counter on the last bit so it never wraps mid-operation.
                if (!last_bit) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    sum_out  <= {fa_sum, s_sh[WIDTH-1:1]};
                    cout_out <= fa_cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH=8 and WIDTH=13
module tb_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        st   [2];
    logic [31:0] a_v  [2];
    logic [31:0] b_v  [2];
    logic        ci   [2];
    logic        bz   [2];
    logic        dn   [2];
    logic        co   [2];
    logic [31:0] so   [2];
    logic        hold [2];

    logic        busy8, done8, cout8, busy13, done13, cout13;
    logic [7:0]  sum8;
    logic [12:0] sum13;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int W [2] = '{8, 13};

    // Reference: result is a+b+cin; timeline is counted in cycles since the accept edge.
    int          t    [2] = '{-1, -1};
    logic [32:0] pend [2];
    logic [31:0] es   [2] = '{32'd0, 32'd0};
    logic        ec   [2] = '{1'b0, 1'b0};
    int          ld   [2] = '{-1, -1};

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a_in(a_v[0][7:0]), .b_in(b_v[0][7:0]),
        .cin_in(ci[0]), .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
    );

    serial_adder #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a_in(a_v[1][12:0]), .b_in(b_v[1][12:0]),
        .cin_in(ci[1]), .busy(busy13), .done(done13), .sum_out(sum13), .cout_out(cout13)
    );

    assign bz[0] = busy8;  assign bz[1] = busy13;
    assign dn[0] = done8;  assign dn[1] = done13;
    assign co[0] = cout8;  assign co[1] = cout13;
    assign so[0] = {24'd0, sum8};
    assign so[1] = {19'd0, sum13};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                t[i] = -1; es[i] = '0; ec[i] = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                logic [31:0] mask;
                mask = (32'd1 << W[i]) - 32'd1;
                if (t[i] < 0) begin
                    if (st[i]) begin
                        t[i]    = 0;
                        pend[i] = {1'b0, a_v[i] & mask} + {1'b0, b_v[i] & mask} + {32'd0, ci[i]};
                    end
                end else if (t[i] == W[i]) begin
                    t[i] = -1;
                end else begin
                    t[i]++;
                    if (t[i] == W[i]) begin
                        es[i] = pend[i][31:0] & mask;
                        ec[i] = pend[i][W[i]];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk(i == 0 ? "busy8" : "busy13", {31'd0, bz[i]}, {31'd0, (t[i] >= 0 && t[i] < W[i])});
                chk(i == 0 ? "done8" : "done13", {31'd0, dn[i]}, {31'd0, (t[i] == W[i])});
                chk(i == 0 ? "sum8" : "sum13", so[i], es[i]);
                chk(i == 0 ? "cout8" : "cout13", {31'd0, co[i]}, {31'd0, ec[i]});
                if (!hold[i]) begin
                    ld[i] = -1;
                end else if (dn[i]) begin
                    if (ld[i] >= 0) chk("period", cyc - ld[i], W[i] + 2);
                    ld[i] = cyc;
                end
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] exp_s, input logic exp_c, input bit repulse);
        int n;
        int nbusy;
        @(negedge clk);
        a_v[0] = {24'd0, a}; b_v[0] = {24'd0, b}; ci[0] = cin; st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        a_v[0] = $urandom; b_v[0] = $urandom; ci[0] = 1'($urandom_range(1));
        n = 0;
        nbusy = 0;
        while (!done8 && n < 40) begin
            if (busy8) nbusy++;
            st[0] = (repulse && n == 3);
            if (repulse && n == 3) begin
                a_v[0] = 32'h0000_0011; b_v[0] = 32'h0000_0022; ci[0] = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        st[0] = 1'b0;
        chk("latency", n + 1, 9);
        chk("busy_cycles", nbusy, 8);
        chk("sum_lit", {24'd0, sum8}, {24'd0, exp_s});
        chk("cout_lit", {31'd0, cout8}, {31'd0, exp_c});
        chk("model_sum", es[0], {24'd0, exp_s});
        @(negedge clk);
        chk("done_pulse", {31'd0, done8}, 32'd0);
    endtask

    task automatic b2b(input int i);
        int ndone;
        int budget;
        ndone  = 0;
        budget = 500 * (W[i] + 2) + 50;
        hold[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b1;
        while (ndone < 500 && budget > 0) begin
            a_v[i] = $urandom; b_v[i] = $urandom; ci[i] = 1'($urandom_range(1));
            @(negedge clk);
            if (dn[i]) ndone++;
            budget--;
        end
        chk(i == 0 ? "b2b_count8" : "b2b_count13", ndone, 500);
        st[i] = 1'b0;
        hold[i] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; ci[i] = 1'b0; hold[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_sum", {24'd0, sum8}, 32'd0);
        chk("rst_cout", {31'd0, cout8}, 32'd0);
        #2 rst_n = 1'b1;

        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        op8(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);

        @(negedge clk);
        a_v[0] = 32'h12; b_v[0] = 32'h34; ci[0] = 1'b0; st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_sum", {24'd0, sum8}, 32'd0);
        chk("abort_cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        fork
            b2b(0);
            b2b(1);
        join
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the existing single-bit `full_adder` cell. It accepts two parallel operands and a carry-in on a start pulse and feeds one bit pair per clock into the full adder, LSB first. A carry flip-flop closes the loop between bits, and the block returns the parallel sum and carry-out with a one-cycle done pulse. It sits between the board's operand source (switch/register stage) and the result display stage, as the sequential consumer of the full adder cell.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk` input 1: single clock, rising-edge active.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only in IDLE.
- `a_in` input WIDTH: operand A; captured on an accepted start.
- `b_in` input WIDTH: operand B; captured on an accepted start.
- `cin_in` input 1: initial carry; captured on an accepted start.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse, high in DONE.
- `sum_out` output WIDTH: registered result; holds until the next completion.
- `cout_out` output 1: registered final carry; holds until the next completion.

## Operation
- FSM states:
  - IDLE: start=1 captures a_in, b_in and cin_in into shift registers a_sh and b_sh and carry flop c_q, clears bit counter cnt, and moves to RUN.
  - RUN: each cycle, `full_adder` takes a_sh[0], b_sh[0] and c_q.
    - Its sum bit shifts into the MSB of s_sh, which shifts right.
    - Its cout loads c_q.
    - a_sh and b_sh shift right.
    - cnt increments.
  - RUN exit: when cnt==WIDTH-1 on that edge, load sum_out with the final s_sh value and cout_out with the full adder's cout, then go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing, no error flag.
- Input changes after capture have no effect on the operation in flight.
- Arithmetic: {cout_out, sum_out} = a_in + b_in + cin_in, computed modulo 2^(WIDTH+1) with no truncation.
- cnt is $clog2(WIDTH) bits wide. cnt never wraps during an operation; it is cleared on each accept.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum_out=0, cout_out=0, c_q=0, cnt=0, shift registers 0.
- Latency:
  - Start is sampled at edge E0.
  - busy is high from after E0 through EWIDTH.
  - sum_out and cout_out update at EWIDTH.
  - done is high during the cycle after EWIDTH.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is the edge at which the block is back in IDLE, i.e. E(WIDTH+2).
- start held continuously: each return to IDLE accepts a new operation.
- Reset asserted mid-RUN or in DONE:
  - The FSM aborts immediately.
  - All outputs go to their reset values.
  - No done is produced for the aborted operation.
- sum_out and cout_out never change except at completion or reset.

## Structure
- Shared header/package holds:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH.
- One sub-module: an instance of the existing `full_adder` (ports a, b, cin, sum, cout), used unmodified.
- Everything else is local: FSM, counter, three shift registers, carry flop and output registers.

## Test plan
- Reset, then a_in=8'h00, b_in=8'h00, cin_in=0, start -> after 8 busy cycles, done pulses once with sum_out=8'h00 and cout_out=0.
- a_in=8'h5A, b_in=8'h33, cin_in=1 -> sum_out=8'h8E, cout_out=0; done appears exactly 9 cycles after the start edge.
- a_in=8'hFF, b_in=8'h01, cin_in=0 -> sum_out=8'h00, cout_out=1, exercising full carry ripple through every bit.
- a_in=8'hFF, b_in=8'hFF, cin_in=1 -> sum_out=8'hFF, cout_out=1. During busy, re-pulse start with different operands -> ignored, result unchanged.
- Start 8'h12+8'h34, assert rst_n=0 at cycle 4 of RUN -> busy, done, sum_out and cout_out go to 0 immediately. After release, start 8'h12+8'h34 -> sum_out=8'h46.
- Back-to-back with start held high, random operands for 500 operations with WIDTH=8 and WIDTH=13 -> every done matches the reference model a+b+cin, and one done occurs per WIDTH+2 cycles.
